// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte sources.
// Latency: accept in IDLE, tx_ready rises next cycle; one frame per FRAME_LEN+1 cycles.
// Backpressure: req_ready is a one-hot combinational strobe, only ever high in IDLE.
module uart_tx_sched #(
  parameter int NUM_REQ  = 4,
  parameter int BAUD_END = 5207,
  parameter int HOLD     = 4,
  parameter int GUARD    = 16
) (
  input  logic                   sys_clk_50M,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [15:0]            frame_cnt_total
);

  // Launch hold + 10 serial bits + idle guard, counted from the first tx_ready cycle.
  localparam int FRAME_LEN = HOLD + 10 * (BAUD_END + 1) + GUARD;
  localparam int CW        = $clog2(FRAME_LEN);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
  localparam logic [2:0]    LAST_REQ   = 3'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            tx_ready_q;
  logic [7:0]      tx_data_q;
  logic            busy_q;
  logic [2:0]      grant_id_q;
  logic [15:0]     frame_cnt_q;

  logic [7:0]      vld8;
  logic [3:0]      idx;
  logic [2:0]      win;
  logic            found;
  logic [7:0]      win_data;

  assign cnt_d = cnt_q + CW'(1);

  // Circular search from grant_id+1; walking offsets high-to-low lets the nearest valid win.
  always_comb begin
    vld8      = 8'(req_valid);
    idx       = '0;
    win       = '0;
    found     = 1'b0;
    win_data  = '0;
    req_ready = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, grant_id_q} + 4'(k);
      if (idx >= 4'(NUM_REQ)) begin
        idx = idx - 4'(NUM_REQ);
      end
      if (vld8[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 3'(i)) begin
        win_data = req_data[8*i +: 8];
      end
      req_ready[i] = (state_q == ST_IDLE) && found && (win == 3'(i));
    end
  end

  // Frame sequencer: accept in IDLE, hold tx_ready for HOLD cycles, then sit out the frame time.
  always_ff @(posedge sys_clk_50M) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tx_ready_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      grant_id_q  <= LAST_REQ;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            state_q     <= ST_LAUNCH;
            cnt_q       <= '0;
            tx_data_q   <= win_data;
            grant_id_q  <= win;
            tx_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end
        end
        ST_LAUNCH: begin
          cnt_q <= cnt_d;
          if (cnt_q == HOLD_LAST) begin
            state_q    <= ST_WAIT;
            tx_ready_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_q == FRAME_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          cnt_q      <= '0;
          tx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready        = tx_ready_q;
  assign tx_data         = tx_data_q;
  assign busy            = busy_q;
  assign grant_id        = grant_id_q;
  assign frame_cnt_total = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small uart_tx line model.
// Simulation build: BAUD_END=56, HOLD=4, GUARD=16 -> FRAME_LEN=590.
// Inputs driven and outputs sampled on the falling edge.
module tb_uart_tx_sched;
  localparam int BE = 56;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        busy;
  logic [2:0]  grant_id;
  logic [15:0] frame_cnt_total;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  uart_tx_sched #(.NUM_REQ(4), .BAUD_END(BE), .HOLD(4), .GUARD(16)) dut (
    .sys_clk_50M(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_ready(tx_ready), .tx_data(tx_data), .busy(busy),
    .grant_id(grant_id), .frame_cnt_total(frame_cnt_total));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx line model: 2-flop sync + edge detect, 10 bits of BE+1 cycles each, LSB first.
  logic       s1 = 0, s2 = 0, s3 = 0, act = 0;
  logic [9:0] sh = '0;
  int         bc = 0, nb = 0;
  bit         bitq[$];
  always @(posedge clk) begin
    s1 <= tx_ready; s2 <= s1; s3 <= s2;
    if (!act && s2 && !s3) begin
      act <= 1'b1; sh <= {1'b1, tx_data, 1'b0}; bc <= 0; nb <= 0;
    end else if (act) begin
      if (bc == BE) begin
        bc <= 0; bitq.push_back(sh[0]); sh <= sh >> 1; nb <= nb + 1;
        if (nb == 9) act <= 1'b0;
      end else begin
        bc <= bc + 1;
      end
    end
  end

  task automatic wait_accept(output bit ok);
    int n = 0;
    #1;
    while (req_ready == 4'b0 && n < 1000) begin @(negedge clk); #1; n++; end
    ok = (req_ready != 4'b0);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    ok = !busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_tx_ready got=%0b exp=0", tx_ready); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (grant_id !== 3'd3) begin bad++; $display("FAIL reset_grant got=%0d exp=3", grant_id); end
    total++; if (frame_cnt_total !== 16'h0) begin bad++; $display("FAIL reset_frame_cnt got=%h exp=0000", frame_cnt_total); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    int nb_c = 0, nt_c = 0, n = 0;
    logic [9:0] got;
    bitq.delete();
    @(negedge clk); req_valid = 4'b0001; req_data[7:0] = 8'hA5; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_req_ready got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = 4'b0; req_data[7:0] = 8'hFF;
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL single_tx_ready_rise got=%0b exp=1", tx_ready); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL single_req_ready_drop got=%b exp=0000", req_ready); end
    total++; if (grant_id !== 3'd0) begin bad++; $display("FAIL single_grant got=%0d exp=0", grant_id); end
    total++; if (frame_cnt_total !== 16'd1) begin bad++; $display("FAIL single_frame_cnt got=%0d exp=1", frame_cnt_total); end
    while (busy && n < 800) begin
      nb_c++; if (tx_ready) nt_c++;
      @(negedge clk); n++;
    end
    total++; if (nb_c != 590) begin bad++; $display("FAIL single_busy_len got=%0d exp=590", nb_c); end
    total++; if (nt_c != 4) begin bad++; $display("FAIL single_hold_len got=%0d exp=4", nt_c); end
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL single_tx_data_stable got=%h exp=a5", tx_data); end
    got = '0;
    for (int j = 0; j < 10 && j < bitq.size(); j++) got[j] = bitq[j];
    total++; if (bitq.size() != 10 || got !== 10'b11_0100_1010) begin
      bad++; $display("FAIL single_line bits=%0d got=%b exp=1101001010", bitq.size(), got);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int prev = 0;
    logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [9:0] got;
    @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
    bitq.delete();
    req_data = 32'h44332211; req_valid = 4'hF;
    for (int f = 0; f < 5; f++) begin
      wait_accept(ok);
      total++; if (!ok || req_ready !== (4'b0001 << (f % 4))) begin
        bad++; $display("FAIL b2b_req_ready frame=%0d got=%b exp=%b", f, req_ready, 4'b0001 << (f % 4));
      end
      @(negedge clk);
      total++; if (grant_id !== 3'(f % 4) || tx_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_grant frame=%0d got=%0d/%0b exp=%0d/1", f, grant_id, tx_ready, f % 4);
      end
      if (f > 0) begin
        total++; if (cyc - prev != 591) begin bad++; $display("FAIL b2b_spacing frame=%0d got=%0d exp=591", f, cyc - prev); end
      end
      prev = cyc;
    end
    req_valid = 4'b0;
    total++; if (bitq.size() < 40) begin
      bad++; $display("FAIL b2b_bitcount got=%0d exp>=40", bitq.size());
    end else begin
      for (int f = 0; f < 4; f++) begin
        for (int j = 0; j < 10; j++) got[j] = bitq[f*10 + j];
        total++; if (got !== {1'b1, exp_b[f], 1'b0}) begin
          bad++; $display("FAIL b2b_line frame=%0d got=%b exp=%b", f, got, {1'b1, exp_b[f], 1'b0});
        end
      end
    end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_idle got=busy exp=idle"); end
  endtask

  task automatic test_fairness;
    bit ok;
    req_valid = 4'b0100;
    wait_accept(ok);
    total++; if (!ok || req_ready !== 4'b0100) begin bad++; $display("FAIL fair_first got=%b exp=0100", req_ready); end
    @(negedge clk); req_valid = 4'b1010;
    wait_accept(ok);
    total++; if (!ok || req_ready !== 4'b1000) begin bad++; $display("FAIL fair_second got=%b exp=1000", req_ready); end
    @(negedge clk);
    wait_accept(ok);
    total++; if (!ok || req_ready !== 4'b0010) begin bad++; $display("FAIL fair_third got=%b exp=0010", req_ready); end
    @(negedge clk); req_valid = 4'b0;
    total++; if (grant_id !== 3'd1) begin bad++; $display("FAIL fair_grant got=%0d exp=1", grant_id); end
    wait_idle(ok);
  endtask

  task automatic test_wait_req;
    bit ok;
    int n = 0, rr_err = 0, tx_err = 0;
    req_valid = 4'b0001;
    wait_accept(ok);
    total++; if (!ok || req_ready !== 4'b0001) begin bad++; $display("FAIL wait_first got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = 4'b0;
    repeat (300) @(negedge clk);
    req_valid = 4'b0010; #1;
    while (busy && n < 800) begin
      if (req_ready != 4'b0) rr_err++;
      if (tx_ready) tx_err++;
      @(negedge clk); #1; n++;
    end
    total++; if (rr_err != 0) begin bad++; $display("FAIL wait_req_ready_early got=%0d exp=0", rr_err); end
    total++; if (tx_err != 0) begin bad++; $display("FAIL wait_tx_glitch got=%0d exp=0", tx_err); end
    total++; if (n != 290) begin bad++; $display("FAIL wait_remaining got=%0d exp=290", n); end
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL wait_accept_idle got=%b exp=0010", req_ready); end
    @(negedge clk); req_valid = 4'b0;
    total++; if (tx_ready !== 1'b1 || grant_id !== 3'd1) begin
      bad++; $display("FAIL wait_launch got=%0b/%0d exp=1/1", tx_ready, grant_id);
    end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid;
    bit ok;
    req_valid = 4'b0001;
    wait_accept(ok);
    @(negedge clk); req_valid = 4'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rmid_tx_ready got=%0b exp=0", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    total++; if (grant_id !== 3'd3) begin bad++; $display("FAIL rmid_grant got=%0d exp=3", grant_id); end
    total++; if (frame_cnt_total !== 16'd0) begin bad++; $display("FAIL rmid_frame_cnt got=%0d exp=0", frame_cnt_total); end
    rst = 1'b0; req_valid = 4'b0011; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rmid_priority got=%b exp=0001", req_ready); end
    @(negedge clk); req_valid = 4'b0;
    total++; if (grant_id !== 3'd0 || frame_cnt_total !== 16'd1) begin
      bad++; $display("FAIL rmid_relaunch got=%0d/%0d exp=0/1", grant_id, frame_cnt_total);
    end
    wait_idle(ok);
  endtask

  task automatic test_wrap;
    bit ok;
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    total++; if (frame_cnt_total !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", frame_cnt_total); end
    req_valid = 4'b0100;
    wait_accept(ok);
    @(negedge clk); req_valid = 4'b0;
    total++; if (frame_cnt_total !== 16'h0000) begin bad++; $display("FAIL wrap_value got=%h exp=0000", frame_cnt_total); end
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_idle got=busy exp=idle"); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_wait_req();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
